// File: rtl/mul8_share_arbiter.sv
// Round-robin sequencer sharing one external 8x8 multiplier among NUM_REQ requesters.
// Latency MUL_LAT edges accept->resp_valid; one op in flight; optional check via MUL8_EXACT_CHECK_EN.
module mul8_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 1,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_result,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [15:0]          resp_data,
  output logic                 resp_err,
  output logic [15:0]          err_cnt,
  output logic                 busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic [CNT_W-1:0] cnt;
  logic [7:0]      op_a;
  logic [7:0]      op_b;

  logic            found;
  int              win_idx;
  int              idx;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] next_ptr;
  logic            accept;
  logic            capture;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    sel_a    = req_a[win_idx*8 +: 8];
    sel_b    = req_b[win_idx*8 +: 8];
    winner   = ID_W'(win_idx);
    next_ptr = ID_W'((win_idx + 1) % NUM_REQ);
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[win_idx] = 1'b1;
  end

  assign accept  = (state == IDLE) && found;
  assign capture = (state == ISSUE) && (cnt == '0);
  assign mul_a   = op_a;
  assign mul_b   = op_b;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_id     <= '0;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            win_id <= winner;
            cnt    <= CNT_W'(MUL_LAT - 1);
            rr_ptr <= next_ptr;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_data  <= mul_result;
            resp_id    <= win_id;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL8_EXACT_CHECK_EN
  // Reference product travels with the operands so the check needs no extra timing.
  logic [15:0] exact;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact    <= '0;
      resp_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (accept) exact <= {8'h00, sel_a} * {8'h00, sel_b};
      if (capture) begin
        resp_err <= (mul_result != exact);
        if (mul_result != exact && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`else
  assign resp_err = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_mul8_share_arbiter.sv
// Directed bench for mul8_share_arbiter: one MUL_LAT=1 and one MUL_LAT=3 instance, queue scoreboard.
module tb_mul8_share_arbiter;

  localparam int NR = 4;

`ifdef MUL8_EXACT_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bad_mul = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   rv1, rv3, rr1, rr3;
  logic [NR*8-1:0] ra, rb;
  logic [7:0]      ma1, mb1, ma3, mb3;
  logic [15:0]     mr1, mr3, rd1, rd3, ec1, ec3;
  logic [1:0]      rid1, rid3;
  logic            rsv1, rsv3, rsr1, rsr3, re1, re3, busy1, busy3;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  // Multiplier models: u1's can be made to return a wrong 255x255 product.
  assign mr1 = (bad_mul && ma1 == 8'd255 && mb1 == 8'd255) ? 16'd65024 : {8'h00, ma1} * {8'h00, mb1};
  assign mr3 = {8'h00, ma3} * {8'h00, mb3};

  mul8_share_arbiter #(.NUM_REQ(NR), .MUL_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_a(ra), .req_b(rb),
    .mul_a(ma1), .mul_b(mb1), .mul_result(mr1), .resp_valid(rsv1), .resp_ready(rsr1),
    .resp_id(rid1), .resp_data(rd1), .resp_err(re1), .err_cnt(ec1), .busy(busy1)
  );

  mul8_share_arbiter #(.NUM_REQ(NR), .MUL_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(rr3), .req_a(ra), .req_b(rb),
    .mul_a(ma3), .mul_b(mb3), .mul_result(mr3), .resp_valid(rsv3), .resp_ready(rsr3),
    .resp_id(rid3), .resp_data(rd3), .resp_err(re3), .err_cnt(ec3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    ra[i*8 +: 8] = a;
    rb[i*8 +: 8] = b;
  endtask

  // Wait (bounded) for a u1 response, compare with the scoreboard head, then accept it.
  task automatic take_resp1(input string tag);
    int n;
    exp_t e;
    n = 0;
    while (!rsv1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rsv1), 32'd1);
    check({tag, "_sbq_nonempty"}, 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check({tag, "_id"}, 32'(rid1), 32'(e.id));
      check({tag, "_data"}, 32'(rd1), 32'(e.data));
      check({tag, "_err"}, 32'(re1), 32'(e.err));
    end
    rsr1 = 1'b1;
    @(negedge clk);
    rsr1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rv1 = '0; rv3 = '0; ra = '0; rb = '0; rsr1 = 1'b0; rsr3 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(rsv1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_ready", 32'(rr1), 32'd0);
    check("rst_mul_a", 32'(ma1), 32'd0);
    check("rst_mul_b", 32'(mb1), 32'd0);
    check("rst_data", 32'(rd1), 32'd0);
    check("rst_id", 32'(rid1), 32'd0);
    check("rst_err", 32'(re1), 32'd0);
    check("rst_err_cnt", 32'(ec1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 2.
    set_op(2, 8'd255, 8'd255);
    rv1 = 4'b0100;
    #1;
    check("single_ready", 32'(rr1), 32'h4);
    sbq.push_back('{id: 2'd2, data: 16'd65025, err: 1'b0});
    @(negedge clk);
    rv1 = '0;
    check("single_busy", 32'(busy1), 32'd1);
    check("single_early", 32'(rsv1), 32'd0);
    check("single_no_ready", 32'(rr1), 32'd0);
    @(negedge clk);
    check("single_lat", 32'(rsv1), 32'd1);
    take_resp1("single");

    // Round robin from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_op(i, 8'd17, 8'd17);
    rv1 = 4'hF;
    for (int g = 0; g < 5; g++) begin
      sbq.push_back('{id: 2'(g % NR), data: 16'd289, err: 1'b0});
      take_resp1("rr");
    end
    rv1 = '0;

    // Backpressure with another requester waiting.
    set_op(0, 8'd23, 8'd67);
    rv1 = 4'b0001;
    sbq.push_back('{id: 2'd0, data: 16'd1541, err: 1'b0});
    @(negedge clk);
    set_op(1, 8'd5, 8'd5);
    rv1 = 4'b0010;
    for (int n = 0; n < 20 && !rsv1; n++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsv1), 32'd1);
      check("bp_data", 32'(rd1), 32'd1541);
      check("bp_no_ready", 32'(rr1), 32'd0);
      @(negedge clk);
    end
    take_resp1("bp");
    check("bp_done_valid", 32'(rsv1), 32'd0);
    check("bp_next_ready", 32'(rr1), 32'h2);
    rv1 = '0;
    @(negedge clk);

    // MUL_LAT=3 latency and operand stability.
    set_op(2, 8'd67, 8'd23);
    rv3 = 4'b0100;
    #1;
    check("lat3_ready", 32'(rr3), 32'h4);
    @(negedge clk);
    rv3 = '0;
    for (int k = 0; k < 3; k++) begin
      check("lat3_early", 32'(rsv3), 32'd0);
      check("lat3_mul_a", 32'(ma3), 32'd67);
      check("lat3_mul_b", 32'(mb3), 32'd23);
      @(negedge clk);
    end
    check("lat3_valid", 32'(rsv3), 32'd1);
    check("lat3_data", 32'(rd3), 32'd1541);
    check("lat3_id", 32'(rid3), 32'd2);
    rsr3 = 1'b1;
    @(negedge clk);
    rsr3 = 1'b0;
    check("lat3_done", 32'(rsv3), 32'd0);
    check("lat3_hold_a", 32'(ma3), 32'd67);
    check("lat3_hold_b", 32'(mb3), 32'd23);

    // Reset while an operation is in ISSUE.
    set_op(3, 8'd9, 8'd9);
    rv1 = 4'b1000;
    @(negedge clk);
    rv1 = '0;
    check("mid_busy", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy1), 32'd0);
    check("mid_rst_valid", 32'(rsv1), 32'd0);
    check("mid_rst_mul_a", 32'(ma1), 32'd0);
    check("mid_rst_ready", 32'(rr1), 32'd0);
    check("mid_rst_data", 32'(rd1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_no_stale", 32'(rsv1), 32'd0);
    end

    // Zero operands from requesters 0, 1, 3.
    set_op(0, 8'd0, 8'd19);
    set_op(1, 8'd19, 8'd0);
    set_op(3, 8'd0, 8'd0);
    rv1 = 4'b1011;
    sbq.push_back('{id: 2'd0, data: 16'd0, err: 1'b0});
    sbq.push_back('{id: 2'd1, data: 16'd0, err: 1'b0});
    sbq.push_back('{id: 2'd3, data: 16'd0, err: 1'b0});
    take_resp1("zero0");
    take_resp1("zero1");
    take_resp1("zero3");
    rv1 = '0;

    // Faulty multiplier product.
    bad_mul = 1'b1;
    set_op(0, 8'd255, 8'd255);
    rv1 = 4'b0001;
    sbq.push_back('{id: 2'd0, data: 16'd65024, err: EXP_CHK});
    @(negedge clk);
    rv1 = '0;
    take_resp1("errchk");
    check("err_cnt_one", 32'(ec1), EXP_CHK ? 32'd1 : 32'd0);
    bad_mul = 1'b0;
    set_op(0, 8'd3, 8'd5);
    rv1 = 4'b0001;
    sbq.push_back('{id: 2'd0, data: 16'd15, err: 1'b0});
    @(negedge clk);
    rv1 = '0;
    take_resp1("errclear");
    check("err_cnt_hold", 32'(ec1), EXP_CHK ? 32'd1 : 32'd0);
    check("sbq_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul8_share_arbiter.md
Name: mul8_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one external 8x8 multiplier (exact or approximate, e.g. the Wallace-tree unit) among NUM_REQ requesters. It accepts one operand pair at a time and drives it to the multiplier. It waits a programmable settle/pipeline latency, then captures the 16-bit product and returns it with the requester ID over a valid/ready response channel. It sits between the accelerator's operand sources and the multiplier under evaluation.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
MUL_LAT, 1, cycles from operands valid on mul_a/mul_b to product sampled; legal range 1..15.
ID_W, $clog2(NUM_REQ), width of resp_id; derived, do not override.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_a  in  NUM_REQ*8  packed operand A; requester i at bits [8i+7:8i]
req_b  in  NUM_REQ*8  packed operand B, same packing
mul_a  out  8  operand A to shared multiplier
mul_b  out  8  operand B to shared multiplier
mul_result  in  16  product from shared multiplier
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_id  out  ID_W  index of requester owning the response
resp_data  out  16  captured product
resp_err  out  1  product mismatch flag (optional feature)
err_cnt  out  16  mismatch counter (optional feature)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rr_ptr=0; mul_a=mul_b=0; resp_valid=0; resp_id=0; resp_data=0; resp_err=0; err_cnt=0; req_ready=0; busy=0. A request in flight is dropped with no response.
- FSM states are IDLE, ISSUE and RESP.
- IDLE transition:
  - Winner = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 combinationally, only in IDLE; all other bits stay 0.
  - On that edge: capture req_a/req_b of the winner into operand registers that drive mul_a/mul_b.
  - Also on that edge: win_id<=winner, cnt<=MUL_LAT-1, rr_ptr<=(winner+1) mod NUM_REQ, go to ISSUE.
  - No valid request: stay in IDLE, rr_ptr unchanged.
- ISSUE: mul_a/mul_b held stable. If cnt!=0, decrement cnt. If cnt==0, on that edge: resp_data<=mul_result, resp_id<=win_id, resp_valid<=1, go to RESP.
- Latency: resp_valid rises at the MUL_LAT-th rising edge after the accepting edge.
- RESP: resp_valid, resp_id, resp_data and resp_err held stable while resp_ready=0. On an edge with resp_ready=1: resp_valid<=0, go to IDLE. No accept happens in RESP.
- Throughput: minimum request spacing is MUL_LAT+2 cycles.
- mul_a/mul_b keep their last operands after the response completes (no toggling); they reset to 0.
- Requester-side rule: req_a/req_b need only be valid in the accepting cycle. A requester may drop req_valid before acceptance without error.
- Fairness: a continuously asserted requester is granted within NUM_REQ grants.
- Zero operands are passed through unchanged; the multiplier result is returned as-is (no bypass).

Optional Feature:
MUL8_EXACT_CHECK_EN
- Defined:
  - The block registers exact = op_a*op_b (16-bit) alongside the operands.
  - At capture: resp_err<=(mul_result!=exact). err_cnt increments by 1 for each mismatched capture and saturates at 16'hFFFF.
  - err_cnt is cleared only by reset.
- Undefined: resp_err and err_cnt are tied to 0; no exact multiplier logic is present.

Test Plan:
- Single request: NUM_REQ=4, MUL_LAT=1, exact multiplier, req 2 sends a=255, b=255 -> req_ready[2] high in IDLE; resp_valid one edge after accept; resp_data=65025, resp_id=2, resp_err=0.
- Round-robin: all four req_valid held high with a=17, b=17 after reset -> grant order 0,1,2,3,0; every resp_data=289.
- Backpressure: a=23, b=67 with resp_ready=0 for 5 cycles -> resp_valid/resp_data=1541 stable throughout; no req_ready in that window; completes on the first resp_ready=1 edge.
- Latency: MUL_LAT=3, a=67, b=23 -> resp_valid rises exactly 3 edges after accept; resp_data=1541; mul_a/mul_b stable for all 3 cycles.
- Zero operands: (0,19), (19,0), (0,0) from requesters 0,1,3 -> resp_data=0 each, resp_id 0,1,3 in order.
- Reset mid-op and optional feature: rst_n low during ISSUE -> all outputs at reset values immediately, no stale response afterward. With MUL8_EXACT_CHECK_EN and a model returning 65024 for 255x255 -> resp_err=1 and err_cnt=1.
